// File: rtl/dmem_burst_engine.sv
// dmem_burst_engine
// Streams bytes into consecutive data-memory addresses (write burst) or out of
// them (read burst). The memory has combinational reads and clocked writes, so
// write strobes are driven straight from the handshake and read data is captured
// into a one-entry output register that gives a 1 byte/cycle stream.
module dmem_burst_engine #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   length,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read,
   output logic          mem_write,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } stateT;

   stateT         state;
   logic [AW-1:0] ptr;
   logic [AW:0]   remaining;
   logic          outValidQ;
   logic [7:0]    outDataQ;

   logic          wrFire;
   logic          rdLoad;
   logic          rdAccept;

   // NOTE: memory strobes are plain continuous assigns of registered state and
   // live inputs, so they can never infer a latch and drop to 0 the instant
   // reset forces the state back to IDLE (no write can commit under reset).
   assign wrFire   = (state == WRITE) && in_valid;
   assign rdLoad   = (state == READ) && (remaining != '0) && (!outValidQ || out_ready);
   assign rdAccept = outValidQ && out_ready;

   assign mem_addr  = ptr;
   assign mem_wdata = in_data;
   assign mem_write = wrFire;
   assign mem_read  = rdLoad;
   assign out_valid = outValidQ;
   assign out_data  = outDataQ;

   // Burst FSM: pointer/count bookkeeping, output register and registered status flags.
   // NOTE: every register here uses non-blocking assignment so all of them see
   // the pre-edge values of state/ptr/remaining, regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         outValidQ <= 1'b0;
         outDataQ  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ptr       <= base_addr;
                  remaining <= length;
                  busy      <= 1'b1;
                  if (length == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (!mode) begin
                     state    <= WRITE;
                     in_ready <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end

            WRITE: begin
               if (in_valid) begin
                  ptr       <= ptr + AW'(1);
                  remaining <= remaining - (AW+1)'(1);
                  if (remaining == (AW+1)'(1)) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     in_ready <= 1'b0;
                  end
               end
            end

            READ: begin
               if (rdLoad) begin
                  // A load refills the output register, which also covers the
                  // case where the previous byte is being accepted this cycle.
                  outDataQ  <= mem_rdata;
                  outValidQ <= 1'b1;
                  ptr       <= ptr + AW'(1);
                  remaining <= remaining - (AW+1)'(1);
               end else if (rdAccept) begin
                  outValidQ <= 1'b0;
                  if (remaining == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_burst_engine.md
# dmem_burst_engine

Byte-stream burst engine in front of the 8-bit-wide, 2**AW-deep data memory: combinational reads, clocked writes, separate read and write enables. It either writes a stream of bytes into consecutive addresses (for example, seeding program 1's integer operands) or reads consecutive addresses out as a stream (for example, dumping the float results for checking). It drives the memory's address, enable and write-data pins directly and consumes its read data. Upstream and downstream sides use valid/ready handshakes.

## Interface
- AW, 8, memory address width; depth is 2**AW.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- mode  input  1  0 = write burst (stream→memory), 1 = read burst (memory→stream); sampled with start.
- base_addr  input  AW  first memory address; sampled with start.
- length  input  AW+1  byte count; sampled with start; 0 is legal.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse at the end of every burst.
- in_valid / in_data  input  1 / 8  write-burst byte source.
- in_ready  output  1  high only in WRITE state.
- out_valid / out_data  output  1 / 8  read-burst byte sink, registered.
- out_ready  input  1  sink accepts out_data.
- mem_addr  output  AW  to DataAddress.
- mem_read  output  1  to ReadMem.
- mem_write  output  1  to WriteMem.
- mem_wdata  output  8  to DataIn.
- mem_rdata  input  8  from DataOut; valid the same cycle mem_read=1.

## Operation
- States: IDLE, WRITE, READ, DONE. Registers: ptr (AW), remaining (AW+1), out_valid, out_data.
- IDLE: on start, load ptr=base_addr and remaining=length.
  - length=0: go to DONE. No memory access occurs.
  - mode=0: go to WRITE.
  - mode=1: go to READ.
- start is ignored outside IDLE.
- WRITE:
  - in_ready=1.
  - On in_valid: mem_write=1, mem_addr=ptr, mem_wdata=in_data, all combinational. Then ptr+=1 and remaining-=1.
  - When remaining==1 and a handshake occurs, go to DONE.
- READ:
  - Load condition: remaining>0 and (!out_valid or out_ready).
  - On a load: mem_read=1, mem_addr=ptr. The cycle captures out_data<=mem_rdata and sets out_valid=1, ptr+=1, remaining-=1.
  - If out_valid&&out_ready and there is no load, clear out_valid.
  - When remaining==0 and the last byte is accepted (out_valid&&out_ready), go to DONE.
  - Sustained throughput is 1 byte/cycle while out_ready=1.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- ptr wraps modulo 2**AW. A length above 2**AW revisits addresses: writes overwrite and reads repeat. This is legal and not flagged.
- Idle memory outputs: mem_read=0, mem_write=0, mem_addr=ptr, mem_wdata=in_data. A memory with ReadMem=0 drives Z; mem_rdata is ignored then.
- Reset (asynchronous, any cycle, including mid-burst):
  - state=IDLE, ptr=0, remaining=0, out_valid=0, out_data=0.
  - busy=0, done=0, in_ready=0, mem_read=0, mem_write=0.
  - No write may commit on an edge where reset_n=0.
  - A partially written burst leaves the already-written bytes in memory. No rollback is performed.

## Timing
- start accepted at edge t: busy=1 from t+1 through the DONE cycle. done=1 in the cycle after the final transfer edge.
- Write latency: a byte handshaken in cycle c is in memory after edge c.
- Read latency: address presented in cycle c; out_valid/out_data appear after edge c, i.e. one cycle after the load.
- length=0: busy and done both high for exactly one cycle, starting the cycle after start.
- Zero-gap back-to-back bursts: start is sampled in the IDLE cycle following DONE.
- out_data holds stable while out_valid=1 and out_ready=0.

## Test plan
- Reset values: pulse reset_n low mid-cycle -> every output goes to 0 immediately, with no clk edge needed.
- Write burst: base=0x10, length=4, bytes 0xA1..0xA4 with in_valid always high -> mem[0x10..0x13]=A1..A4, done pulses at cycle 5 after start, busy high for cycles 1–5.
- Read burst with backpressure: preload mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33. base=0xFE, length=3, out_ready toggled 1,0,0,1,1 -> stream 11,22,33 in order with wrap; out_data stable while stalled; no extra mem_read pulses.
- length=0, both modes -> done and busy high for one cycle; mem_read and mem_write never asserted.
- Mid-burst reset: write burst length=8 to base=0x20, assert reset_n after 3 bytes -> mem[0x20..0x22] written, mem[0x23..0x27] unchanged, engine idle and accepts a new start afterwards.
- start ignored while busy: a second start during a read burst of length=2 -> exactly one done pulse; the first burst's addresses are used.
